// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder steps LSB-first through WIDTH bits per operation.
// Optional subtract mode (adds port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  always_comb begin
    w_s    = fa_sum(r_a[0], r_b[0], r_carry);
    w_co   = fa_carry(r_a[0], r_b[0], r_carry);
    w_last = (r_cnt == LAST);
  end

  // Subtraction is a + ~b + 1, so cout=1 means no borrow.
  always_comb begin
    w_b_load = b;
    w_c_load = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      w_b_load = ~b;
      w_c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter holds at WIDTH-1 on the final bit instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_part  <= {w_s, r_part[WIDTH-1:1]};
          r_carry <= w_co;
          if (w_last) begin
            r_sum  <= {w_s, r_part[WIDTH-1:1]};
            r_cout <= w_co;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
